// File: rtl/lsu.sv
// rtl/lsu.sv - multi-cycle load/store unit with valid/ready data bus
//
// Purpose:
//   Takes one load or store from the decoder, runs a single request/response
//   transaction on the data bus and returns the lane-aligned, extended load
//   result. Holds the core (stall) while the access is in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_r_en/mem_w_en load/store request (both high = store)
//   mem_mask          size mask 0001 byte, 0011 half, 1111 word
//   funct3            load extension select
//   addr, wdata       byte address and lane-0 aligned store data
//   stall             core hold while access unfinished
//   done              1-cycle completion pulse, qualifies rdata/err
//   rdata, err        extended load data / bus error of completed access
//   misalign          1-cycle pulse: misaligned access rejected
//   bus_req_*         request channel (valid/ready, we, addr, wstrb, wdata)
//   bus_resp_*        response channel (valid/ready, rdata, err)

module lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   input  logic [3:0]            mem_mask,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic                  misalign,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_wstrb,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_resp_valid,
   output logic                  bus_resp_ready,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_resp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nx;

   // Captured copy of the access; the core's inputs are ignored after capture.
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            wstrb_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            funct3_q;
   logic [1:0]            offset_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  start;
   logic                  misaligned;
   logic                  accept;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] ext_data;

   assign start      = mem_r_en | mem_w_en;
   assign misaligned = ((mem_mask == 4'b0011) & addr[0]) |
                       ((mem_mask == 4'b1111) & (addr[1:0] != 2'b00));
   assign accept     = (state == S_IDLE) & start & ~misaligned;

   // Bring the addressed lane down to bit 0, then extend per load type.
   assign shifted = bus_rdata >> {offset_q, 3'b000};

   always_comb begin
      ext_data = shifted;
      case (funct3_q)
         3'b000:  ext_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  ext_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: ext_data = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wstrb_q  <= 4'b0000;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         offset_q <= 2'b00;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            // A simultaneous read and write request is handled as a store.
            we_q     <= mem_w_en;
            addr_q   <= {addr[ADDR_WIDTH-1:2], 2'b00};
            wstrb_q  <= mem_mask << addr[1:0];
            wdata_q  <= wdata << {addr[1:0], 3'b000};
            funct3_q <= funct3;
            offset_q <= addr[1:0];
         end
         if ((state == S_RESP) && bus_resp_valid) begin
            rdata_q <= (bus_resp_err | we_q) ? '0 : ext_data;
            err_q   <= bus_resp_err;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_REQ;
         S_REQ:   if (bus_req_ready) state_nx = S_RESP;
         // A response offered while still in REQ is not consumed here.
         S_RESP:  if (bus_resp_valid) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      stall          = 1'b0;
      done           = 1'b0;
      rdata          = '0;
      err            = 1'b0;
      misalign       = 1'b0;
      bus_req_valid  = 1'b0;
      bus_we         = 1'b0;
      bus_addr       = '0;
      bus_wstrb      = 4'b0000;
      bus_wdata      = '0;
      bus_resp_ready = 1'b0;
      case (state)
         S_IDLE: begin
            stall    = accept;
            misalign = start & misaligned;
         end
         S_REQ: begin
            stall         = 1'b1;
            bus_req_valid = 1'b1;
            bus_we        = we_q;
            bus_addr      = addr_q;
            bus_wstrb     = wstrb_q;
            bus_wdata     = wdata_q;
         end
         S_RESP: begin
            stall          = 1'b1;
            bus_resp_ready = 1'b1;
         end
         S_DONE: begin
            done  = 1'b1;
            rdata = rdata_q;
            err   = err_q;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

endmodule
